ram_dump_reader: RTL and testbench
==================================

# ram_dump_reader

Read-out engine for the 16×8 program/data RAM. On a `start` pulse, normally wired to the control sequencer's `HLT`, it walks a configurable address window and streams each RAM byte, tagged with its address, over a valid/ready interface. It is the read-side counterpart of the RAM load port (`input_mode` / `input_address` / `input_program`). While `busy`, it owns the RAM address mux; the CPU is halted.

## Interface
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 8: RAM word width.
- `FIRST_ADDR`, 4'h0: first address dumped.
- `LAST_ADDR`, 4'hF: last address dumped.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a dump.
- `ram_addr`  out  ADDR_W  read address to the RAM dump port.
- `ram_rdata`  in  DATA_W  RAM read data, registered, valid 1 cycle after `ram_addr`.
- `ram_sel`  out  1  1 = RAM address mux selects `ram_addr`; equals `busy`.
- `dout_data`  out  DATA_W  streamed word.
- `dout_addr`  out  ADDR_W  address of `dout_data`.
- `dout_valid`  out  1  stream word valid.
- `dout_ready`  in  1  sink accepts the word.
- `dout_last`  out  1  marks the final beat of the dump.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, SEND, FINISH.
- **IDLE**
  - `start` = 1: load `cur` ← FIRST_ADDR and go to ISSUE.
  - `start` = 0: stay in IDLE.
- **ISSUE**
  - Drive `ram_addr` = `cur`, then go to CAPTURE.
- **CAPTURE**
  - Latch `ram_rdata` into `dout_data` and `cur` into `dout_addr`.
  - Set `dout_valid`, then go to SEND.
- **SEND**
  - Hold `dout_data`, `dout_addr`, `dout_valid` and `dout_last` stable until `dout_ready` = 1.
  - On acceptance, if `cur` == LAST_ADDR: go to FINISH.
  - Otherwise: `cur` ← `cur` + 1 mod 2^ADDR_W, then go to ISSUE.
- **FINISH**
  - Pulse `done` for 1 cycle, then go to IDLE.
- Window wraps: FIRST_ADDR > LAST_ADDR dumps FIRST..F, then 0..LAST. Word count = ((LAST−FIRST) mod 2^ADDR_W) + 1.
- FIRST_ADDR == LAST_ADDR dumps exactly one word, with `dout_last` = 1.
- `dout_last` = 1 only on the beat whose address is LAST_ADDR (or the checksum beat when enabled).
- `start` while `busy` is ignored. `start` in the same cycle as `done` is ignored.
- `busy` = 1 in ISSUE, CAPTURE, SEND and FINISH; 0 in IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `ram_sel`, `dout_valid`, `dout_last`, `done` = 0.
  - `ram_addr` = FIRST_ADDR.
  - `dout_data`, `dout_addr` = 0.
- Reset mid-dump: next cycle is IDLE with all outputs at reset values. No partial `done` is emitted.
- Latency: `start` at cycle 0 gives `dout_valid` = 1 at cycle 3 (IDLE→ISSUE→CAPTURE→SEND).
- Throughput with `dout_ready` held at 1: one word every 3 cycles.
- `done` asserts the cycle after the last acceptance.
- `dout_valid` never drops without acceptance. Data changes only after a cycle with `dout_valid` & `dout_ready`.

## Configuration
- `RAM_DUMP_CHECKSUM_EN` defined:
  - An 8-bit accumulator sums every dumped word, mod 256, clearing on `start`.
  - After the LAST_ADDR beat, one extra SEND beat carries `dout_data` = sum, `dout_addr` = 0, `dout_last` = 1.
  - The LAST_ADDR beat then has `dout_last` = 0.
  - `done` follows the checksum beat's acceptance.
- Not defined: no accumulator and no extra beat.

## Structure
- Shared package `sap_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `dump_state_t` enum (IDLE, ISSUE, CAPTURE, SEND, FINISH, plus CKSUM when enabled).
- Single module; the checksum accumulator is inline under the macro, with no sub-module.
- The RAM gains a registered read port addressed by `ram_addr` when `ram_sel` = 1.

## Test plan
- Single word: RAM[9]=0Ah, FIRST=LAST=9, `start`, `dout_ready`=1 → one beat (addr 9, data 0Ah, `dout_last`=1) at cycle 3; `done` at cycle 4.
- Program window: RAM[0..5]=79h,30h,C0h,7Ah,30h,D0h, FIRST=0, LAST=5 → six beats in address order; `dout_last` only on addr 5; `done` once.
- Backpressure: hold `dout_ready`=0 for 5 cycles on the addr-1 beat → data 30h, addr 1 held stable throughout; no beat lost or duplicated.
- Wrap: FIRST=Eh, LAST=1h → beat addresses E, F, 0, 1.
- Reset mid-dump: assert `reset` during the 3rd beat's SEND → IDLE next cycle, `busy`=0, no `done`. A new `start` restarts from FIRST_ADDR.
- Checksum (macro on): RAM[9]=0Ah, RAM[A]=0Bh, FIRST=9, LAST=A → beats 0Ah, 0Bh, then checksum 15h with `dout_last`=1. `start` asserted while busy has no effect.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and FSM encoding for the RAM dump reader.
// Build option: RAM_DUMP_CHECKSUM_EN appends a mod-256 checksum beat to each dump.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
`ifdef RAM_DUMP_CHECKSUM_EN
    ,
    CKSUM   = 3'd5
`endif
  } dump_state_t;

endpackage

// File: rtl/ram_dump_reader_if.sv
// Valid/ready stream carrying one RAM word tagged with its address.
interface ram_dump_reader_if;
  import sap_pkg::*;

  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, addr, valid, last, input ready);
  modport slave  (input data, addr, valid, last, output ready);

endinterface

// File: rtl/ram_dump_reader.sv
// Walks the FIRST_ADDR..LAST_ADDR window (wrapping) of the 16x8 RAM and streams each word.
// Build option: RAM_DUMP_CHECKSUM_EN adds a trailing checksum beat (addr 0, last = 1).
module ram_dump_reader
  import sap_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FIRST_ADDR = 4'h0,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_sel,
  ram_dump_reader_if.master dout,
  output logic              busy,
  output logic              done
);

  dump_state_t       state;
  logic [ADDR_W-1:0] cur;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  // The RAM read port is registered, so driving cur straight out lets ISSUE
  // present the address and CAPTURE see the word one cycle later.
  assign ram_addr = cur;
  assign busy     = (state != IDLE);
  assign ram_sel  = busy;
  assign done     = (state == FINISH);

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values of cur/state, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= FIRST_ADDR;
      dout.data  <= '0;
      dout.addr  <= '0;
      dout.valid <= 1'b0;
      dout.last  <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur   <= FIRST_ADDR;
            state <= ISSUE;
`ifdef RAM_DUMP_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end

        ISSUE: state <= CAPTURE;

        CAPTURE: begin
          dout.data  <= ram_rdata;
          dout.addr  <= cur;
          dout.valid <= 1'b1;
          dout.last  <= (cur == LAST_ADDR) && !CKSUM_ON;
`ifdef RAM_DUMP_CHECKSUM_EN
          sum        <= sum + ram_rdata;
`endif
          state      <= SEND;
        end

        SEND: begin
          if (dout.ready) begin
            if (cur == LAST_ADDR) begin
`ifdef RAM_DUMP_CHECKSUM_EN
              // Checksum beat follows back-to-back; valid stays high.
              dout.data <= sum;
              dout.addr <= '0;
              dout.last <= 1'b1;
              state     <= CKSUM;
`else
              dout.valid <= 1'b0;
              dout.last  <= 1'b0;
              state      <= FINISH;
`endif
            end else begin
              dout.valid <= 1'b0;
              dout.last  <= 1'b0;
              cur        <= cur + 1'b1;
              state      <= ISSUE;
            end
          end
        end

`ifdef RAM_DUMP_CHECKSUM_EN
        CKSUM: begin
          if (dout.ready) begin
            dout.valid <= 1'b0;
            dout.last  <= 1'b0;
            state      <= FINISH;
          end
        end
`endif

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench: four reader instances with different windows share one RAM image.
// Build option: RAM_DUMP_CHECKSUM_EN switches expectations to include the checksum beat.
module tb_ram_dump_reader;
  import sap_pkg::*;

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] start = '0;
  logic [3:0] ready = 4'hF;

  logic [7:0] mem   [16];
  logic [7:0] rdata [4];
  logic [3:0] raddr [4];
  logic       sel   [4];
  logic       bsy   [4];
  logic       dn    [4];
  logic       vld   [4];
  logic       lst   [4];
  logic [7:0] dat   [4];
  logic [3:0] adr   [4];
  int         done_cnt [4] = '{0, 0, 0, 0};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_dump_reader_if s0 ();
  ram_dump_reader_if s1 ();
  ram_dump_reader_if s2 ();
  ram_dump_reader_if s3 ();

  ram_dump_reader #(.FIRST_ADDR(4'h9), .LAST_ADDR(4'h9)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .ram_addr(raddr[0]), .ram_rdata(rdata[0]),
    .ram_sel(sel[0]), .dout(s0), .busy(bsy[0]), .done(dn[0]));
  ram_dump_reader #(.FIRST_ADDR(4'h0), .LAST_ADDR(4'h5)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .ram_addr(raddr[1]), .ram_rdata(rdata[1]),
    .ram_sel(sel[1]), .dout(s1), .busy(bsy[1]), .done(dn[1]));
  ram_dump_reader #(.FIRST_ADDR(4'hE), .LAST_ADDR(4'h1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .ram_addr(raddr[2]), .ram_rdata(rdata[2]),
    .ram_sel(sel[2]), .dout(s2), .busy(bsy[2]), .done(dn[2]));
  ram_dump_reader #(.FIRST_ADDR(4'h9), .LAST_ADDR(4'hA)) u3 (
    .clk(clk), .reset(reset), .start(start[3]), .ram_addr(raddr[3]), .ram_rdata(rdata[3]),
    .ram_sel(sel[3]), .dout(s3), .busy(bsy[3]), .done(dn[3]));

  assign s0.ready = ready[0];
  assign s1.ready = ready[1];
  assign s2.ready = ready[2];
  assign s3.ready = ready[3];

  assign vld[0] = s0.valid;  assign lst[0] = s0.last;  assign dat[0] = s0.data;  assign adr[0] = s0.addr;
  assign vld[1] = s1.valid;  assign lst[1] = s1.last;  assign dat[1] = s1.data;  assign adr[1] = s1.addr;
  assign vld[2] = s2.valid;  assign lst[2] = s2.last;  assign dat[2] = s2.data;  assign adr[2] = s2.addr;
  assign vld[3] = s3.valid;  assign lst[3] = s3.last;  assign dat[3] = s3.data;  assign adr[3] = s3.addr;

  // Registered RAM dump port, one per reader.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (sel[i]) rdata[i] <= mem[raddr[i]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dn[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int i);
    int c;
    c = 0;
    while (vld[i] !== 1'b1 && c < 12) begin
      tick();
      c++;
    end
  endtask

  // Checks one beat, lets it be accepted, and optionally checks valid drops after.
  task automatic beat(input int i, input string tag, input logic [3:0] ea,
                      input logic [7:0] ed, input logic el, input logic gap);
    wait_valid(i);
    check({tag, " valid"}, 32'(vld[i]), 32'd1);
    check({tag, " addr"},  32'(adr[i]), 32'(ea));
    check({tag, " data"},  32'(dat[i]), 32'(ed));
    check({tag, " last"},  32'(lst[i]), 32'(el));
    tick();
    if (gap) check({tag, " gap"}, 32'(vld[i]), 32'd0);
  endtask

  task automatic fin(input int i, input string tag);
    check({tag, " done"}, 32'(dn[i]), 32'd1);
    check({tag, " busy"}, 32'(bsy[i]), 32'd1);
    tick();
    check({tag, " done off"}, 32'(dn[i]), 32'd0);
    check({tag, " idle"},     32'(bsy[i]), 32'd0);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic prog_beats(input string tag, input int from);
    logic [7:0] prog [6];
    prog = '{8'h79, 8'h30, 8'hC0, 8'h7A, 8'h30, 8'hD0};
    for (int k = from; k < 6; k++)
      beat(1, $sformatf("%s%0d", tag, k), 4'(k), prog[k], (k == 5) && !CK, !((k == 5) && CK));
`ifdef RAM_DUMP_CHECKSUM_EN
    beat(1, {tag, " ck"}, 4'h0, 8'hE3, 1'b1, 1'b1);
`endif
  endtask

  initial begin
    logic [3:0] first_tab [4];
    first_tab = '{4'h9, 4'h0, 4'hE, 4'h9};
    for (int a = 0; a < 16; a++) mem[a] = 8'(a * 17);
    mem[0] = 8'h79; mem[1] = 8'h30; mem[2] = 8'hC0; mem[3] = 8'h7A;
    mem[4] = 8'h30; mem[5] = 8'hD0; mem[9] = 8'h0A; mem[10] = 8'h0B;
    mem[14] = 8'hE1; mem[15] = 8'hF2;

    tick();
    tick();
    reset = 1'b0;

    // Reset state of every instance
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d busy", i),  32'(bsy[i]), 32'd0);
      check($sformatf("rst%0d sel", i),   32'(sel[i]), 32'd0);
      check($sformatf("rst%0d valid", i), 32'(vld[i]), 32'd0);
      check($sformatf("rst%0d last", i),  32'(lst[i]), 32'd0);
      check($sformatf("rst%0d done", i),  32'(dn[i]),  32'd0);
      check($sformatf("rst%0d data", i),  32'(dat[i]), 32'd0);
      check($sformatf("rst%0d addr", i),  32'(adr[i]), 32'd0);
      check($sformatf("rst%0d ram_addr", i), 32'(raddr[i]), 32'(first_tab[i]));
    end

    // Single word: exact latency, start at cycle 0
    pulse_start(0);
    check("sw c1 busy", 32'(bsy[0]), 32'd1);
    check("sw c1 sel", 32'(sel[0]), 32'd1);
    check("sw c1 ram_addr", 32'(raddr[0]), 32'h9);
    check("sw c1 valid", 32'(vld[0]), 32'd0);
    tick();
    check("sw c2 valid", 32'(vld[0]), 32'd0);
    tick();
    check("sw c3 valid", 32'(vld[0]), 32'd1);
    check("sw c3 addr", 32'(adr[0]), 32'h9);
    check("sw c3 data", 32'(dat[0]), 32'h0A);
    check("sw c3 last", 32'(lst[0]), 32'(!CK));
    tick();
`ifdef RAM_DUMP_CHECKSUM_EN
    beat(0, "sw ck", 4'h0, 8'h0A, 1'b1, 1'b1);
`endif
    fin(0, "sw");
    check("sw done count", 32'(done_cnt[0]), 32'd1);

    // Program window with backpressure on the addr-1 beat
    pulse_start(1);
    beat(1, "p0", 4'h0, 8'h79, 1'b0, 1'b1);
    wait_valid(1);
    ready[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp%0d valid", k), 32'(vld[1]), 32'd1);
      check($sformatf("bp%0d data", k),  32'(dat[1]), 32'h30);
      check($sformatf("bp%0d addr", k),  32'(adr[1]), 32'h1);
    end
    ready[1] = 1'b1;
    prog_beats("p", 1);
    fin(1, "prog");
    check("prog done count", 32'(done_cnt[1]), 32'd1);

    // Reset during the third beat's SEND, then restart
    pulse_start(1);
    beat(1, "m0", 4'h0, 8'h79, 1'b0, 1'b1);
    beat(1, "m1", 4'h1, 8'h30, 1'b0, 1'b1);
    wait_valid(1);
    ready[1] = 1'b0;
    check("mid third beat addr", 32'(adr[1]), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready[1] = 1'b1;
    check("mid busy", 32'(bsy[1]), 32'd0);
    check("mid sel", 32'(sel[1]), 32'd0);
    check("mid valid", 32'(vld[1]), 32'd0);
    check("mid data", 32'(dat[1]), 32'd0);
    check("mid ram_addr", 32'(raddr[1]), 32'h0);
    check("mid done", 32'(dn[1]), 32'd0);
    tick();
    check("mid done later", 32'(dn[1]), 32'd0);
    pulse_start(1);
    prog_beats("r", 0);
    fin(1, "restart");
    check("restart done count", 32'(done_cnt[1]), 32'd2);

    // Wrapping window E..1
    pulse_start(2);
    check("wrap ram_addr", 32'(raddr[2]), 32'hE);
    beat(2, "wE", 4'hE, 8'hE1, 1'b0, 1'b1);
    beat(2, "wF", 4'hF, 8'hF2, 1'b0, 1'b1);
    beat(2, "w0", 4'h0, 8'h79, 1'b0, 1'b1);
    beat(2, "w1", 4'h1, 8'h30, !CK, !CK);
`ifdef RAM_DUMP_CHECKSUM_EN
    beat(2, "w ck", 4'h0, 8'h7C, 1'b1, 1'b1);
`endif
    fin(2, "wrap");

    // Window 9..A with start pulses while busy and on the done cycle
    pulse_start(3);
    tick();
    pulse_start(3);
    beat(3, "c9", 4'h9, 8'h0A, 1'b0, 1'b1);
    beat(3, "cA", 4'hA, 8'h0B, !CK, !CK);
`ifdef RAM_DUMP_CHECKSUM_EN
    beat(3, "c ck", 4'h0, 8'h15, 1'b1, 1'b1);
`endif
    check("c done", 32'(dn[3]), 32'd1);
    pulse_start(3);
    check("c start on done busy", 32'(bsy[3]), 32'd0);
    tick();
    check("c start on done stays idle", 32'(bsy[3]), 32'd0);
    check("c done count", 32'(done_cnt[3]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
